// File: rtl/dft_bin_collector.sv
// Serial DFT bin collector: smooths each incoming bin with a per-bin first-order
// IIR filter. When a full frame is gathered, it publishes the frame to the NoteFinder
// and holds it there until the NoteFinder reports finished.
module dft_bin_collector #(
    parameter int unsigned  N    = 16,
    parameter int unsigned  BPO  = 24,
    parameter int unsigned  OCT  = 5,
    localparam int unsigned BINS = BPO * OCT,
    localparam int unsigned IW   = $clog2(BINS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inValid,
    input  logic          inFirst,
    input  logic [N-1:0]  inData,
    input  logic [3:0]    iirShift,
    input  logic          finished,
    output logic [N-1:0]  dftBins [0:BINS-1],
    output logic          startCycle,
    output logic          busy,
    output logic [IW-1:0] binIndex,
    output logic [7:0]    droppedFrames,
    output logic          syncError
);

    logic [N-1:0]  filt_q      [0:BINS-1];
    logic [N-1:0]  filt_d      [0:BINS-1];
    logic [N-1:0]  dft_bins_q  [0:BINS-1];
    logic [N-1:0]  dft_bins_d  [0:BINS-1];
    logic          start_cycle_q, start_cycle_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] bin_index_q, bin_index_d;
    logic [7:0]    dropped_q, dropped_d;
    logic          sync_error_q, sync_error_d;

    logic [IW-1:0]     j;
    logic [3:0]        k;
    logic signed [N:0] diff;
    logic signed [N:0] step;
    logic [N-1:0]      new_val;
    logic              last_bin;
    logic              complete;
    logic              publish_ok;

    // Filter datapath for the bin being accepted this cycle
    always_comb begin
        j = inFirst ? '0 : bin_index_q;
        // Shift values at or beyond the sample width saturate to N-1
        k = (int'(iirShift) >= int'(N)) ? 4'(N - 1) : iirShift;
        diff = {1'b0, inData} - {1'b0, filt_q[j]};
        step = diff >>> k;
        // The result always lies between the old value and inData, so truncation is exact
        new_val = filt_q[j] + step[N-1:0];
        last_bin = (j == IW'(BINS - 1));
        complete = inValid && last_bin;
        // A finished pulse on the completing edge frees the slot for the new frame
        publish_ok = !busy_q || finished;
    end

    // Next-state: filter array, index, publish/drop bookkeeping
    always_comb begin
        filt_d        = filt_q;
        dft_bins_d    = dft_bins_q;
        start_cycle_d = 1'b0;
        busy_d        = busy_q;
        bin_index_d   = bin_index_q;
        dropped_d     = dropped_q;
        sync_error_d  = sync_error_q;

        if (inValid) begin
            filt_d[j]   = new_val;
            bin_index_d = last_bin ? '0 : j + 1'b1;
            if (inFirst && (bin_index_q != '0)) begin
                sync_error_d = 1'b1;
            end
        end

        if (complete) begin
            if (publish_ok) begin
                dft_bins_d    = filt_d;
                start_cycle_d = 1'b1;
                busy_d        = 1'b1;
            end else if (dropped_q != 8'hFF) begin
                dropped_d = dropped_q + 8'd1;
            end
        end else if (finished) begin
            busy_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q        <= '{default: '0};
            dft_bins_q    <= '{default: '0};
            start_cycle_q <= 1'b0;
            busy_q        <= 1'b0;
            bin_index_q   <= '0;
            dropped_q     <= '0;
            sync_error_q  <= 1'b0;
        end else begin
            filt_q        <= filt_d;
            dft_bins_q    <= dft_bins_d;
            start_cycle_q <= start_cycle_d;
            busy_q        <= busy_d;
            bin_index_q   <= bin_index_d;
            dropped_q     <= dropped_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign dftBins       = dft_bins_q;
    assign startCycle    = start_cycle_q;
    assign busy          = busy_q;
    assign binIndex      = bin_index_q;
    assign droppedFrames = dropped_q;
    assign syncError     = sync_error_q;

endmodule
